byte_queue: RTL
===============

# byte_queue

Downstream stage of the deserializer: captures each 8-bit word the deserializer presents on its `data_ready`/`data_out` pair, acknowledges it, and stores it in an 8-entry circular FIFO. It exposes the stored words to the consumer through a dequeue strobe and reports the current occupancy. When full, it withholds the acknowledge, so the deserializer holds its word and stays busy. This provides backpressure without data loss. Runs on the same 100 kHz clock as the deserializer.

## Interface
- `DEPTH`, default 8: number of entries; must be a power of two, ≥ 2.
- `WIDTH`, default 8: word width in bits; matches the deserializer output.

- `clock`  in  1  system clock, 100 kHz, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `data_in`  in  WIDTH  word from the deserializer's `data_out`.
- `data_ready_in`  in  1  deserializer's `data_ready`; high while a word is pending.
- `ack_out`  out  1  to the deserializer's `ack_in`; one-cycle pulse per captured word.
- `dequeue_in`  in  1  consumer request to pop one word.
- `data_out`  out  WIDTH  last dequeued word; held until the next successful dequeue.
- `data_valid_out`  out  1  one-cycle pulse when `data_out` is updated.
- `len_out`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `full_out`  out  1  high when `len_out == DEPTH`.
- `empty_out`  out  1  high when `len_out == 0`.

## Operation
- Storage: `DEPTH` × `WIDTH` register array.
  - Write pointer `wr_ptr` and read pointer `rd_ptr` are each $clog2(DEPTH) bits and wrap modulo `DEPTH` with natural overflow.
  - Occupancy `count` is $clog2(DEPTH)+1 bits.
- Capture FSM, states `WAIT_DATA`, `ACK`, `WAIT_DROP`:
  - `WAIT_DATA`: if `data_ready_in` is high and `count < DEPTH`, write `mem[wr_ptr] <= data_in`, increment `wr_ptr`, go to `ACK`. Otherwise stay.
  - `ACK`: `ack_out` = 1 (Moore output, registered). Go unconditionally to `WAIT_DROP`.
  - `WAIT_DROP`: wait for `data_ready_in` == 0, then go to `WAIT_DATA`. This prevents a second capture of the same word.
- Dequeue: if `dequeue_in` is high and `count > 0`:
  - `data_out <= mem[rd_ptr]`, increment `rd_ptr`.
  - `data_valid_out <= 1` for exactly one cycle.
- Dequeue on empty: ignored; `data_out` holds its value; `data_valid_out` stays 0.
- Count update per cycle: +1 on capture only, −1 on dequeue only, unchanged on both or neither.
- Full condition:
  - The capture decision uses the registered `count`. A word pending while full is not captured in the same cycle as a dequeue that frees space.
  - That word is captured on the next cycle.
  - `ack_out` stays 0 while full, so the upstream word and `data_ready` are held.
- Simultaneous capture and dequeue at `0 < count < DEPTH`: both take effect; `len_out` is unchanged.
- Capture on empty plus dequeue in the same cycle: the dequeue is ignored, since `count` was 0. The word becomes readable next cycle.
- `full_out`, `empty_out` and `len_out` are decoded from registered `count`; they are never computed from inputs.

## Timing
- Reset values:
  - `ack_out` = 0, `data_out` = 0, `data_valid_out` = 0.
  - `len_out` = 0, `full_out` = 0, `empty_out` = 1.
  - Pointers = 0, FSM = `WAIT_DATA`.
- Capture latency: `data_ready_in` sampled high at edge N (not full) gives `ack_out` high during cycle N+1 and `len_out` incremented after edge N.
- The deserializer drops `data_ready` after seeing `ack_in`. The FSM therefore spends at least one cycle in `WAIT_DROP`.
- Minimum spacing between captures is 3 cycles.
- Dequeue latency: `dequeue_in` sampled at edge N gives `data_out`/`data_valid_out` valid during cycle N+1.
- Back-to-back dequeues are allowed every cycle.
- Reset mid-operation:
  - Contents are discarded and any in-flight ack is cancelled.
  - If `data_ready_in` is still high after reset deassertion, that word is captured as a new entry.
- `ack_out` is never high for more than one consecutive cycle.

## Structure
- Shared package `deserializer_pkg`:
  - `typedef enum logic [1:0] {WAIT_DATA, ACK, WAIT_DROP} capture_state_t`.
  - Localparams `QUEUE_DEPTH = 8` and `WORD_WIDTH = 8`, used as the default parameter values.
- One sub-module, `byte_queue_mem`: the register array with one synchronous write port and one synchronous read port, with no reset on contents.
- The top holds the FSM, pointers, count and output registers.

## Test plan
- Reset then one word: deserializer presents 0xA5 → one `ack_out` pulse; `len_out` = 1; `empty_out` = 0. A later dequeue gives `data_out` = 0xA5 with a one-cycle `data_valid_out`; `len_out` = 0.
- Fill and order: enqueue 0x01..0x08 → `full_out` = 1, `len_out` = 8. Eight dequeues return 0x01..0x08 in order; `empty_out` = 1 afterwards.
- Backpressure: while full, present 0x99 for 20 cycles → `ack_out` stays 0 and `len_out` stays 8. One dequeue → 0x99 captured on the following cycle, with exactly one ack.
- Simultaneous: with `len_out` = 3, capture 0x55 and dequeue in the same cycle → `len_out` stays 3; the dequeued word is the oldest entry.
- Wrap and empty: 12 enqueue/dequeue pairs (0x10..0x1B) → correct order across the pointer wrap. Dequeue on empty → `data_out` holds 0x1B and `data_valid_out` stays 0.
- Async reset with `len_out` = 5 and FSM in `ACK` → all outputs at reset values immediately; no further `ack_out` pulse until a new `data_ready_in` is seen.

Source files
------------

// File: rtl/byte_queue_pkg.sv
// Shared types and default sizes for the deserializer output path.
// The byte_queue capture FSM and its default geometry live here.
package deserializer_pkg;

    localparam int QUEUE_DEPTH = 8;
    localparam int WORD_WIDTH  = 8;

    typedef enum logic [1:0] {
        WAIT_DATA,
        ACK,
        WAIT_DROP
    } capture_state_t;

endpackage

// File: rtl/byte_queue_if.sv
// Handshake bundle between the deserializer, the byte_queue and its consumer.
// The master side drives words and dequeue requests; the slave side is the queue.
interface byte_queue_if #(
    parameter int DEPTH = deserializer_pkg::QUEUE_DEPTH,
    parameter int WIDTH = deserializer_pkg::WORD_WIDTH
);

    logic [WIDTH-1:0]        data_in;
    logic                    data_ready_in;
    logic                    ack_out;
    logic                    dequeue_in;
    logic [WIDTH-1:0]        data_out;
    logic                    data_valid_out;
    logic [$clog2(DEPTH):0]  len_out;
    logic                    full_out;
    logic                    empty_out;

    modport master (
        output data_in, data_ready_in, dequeue_in,
        input  ack_out, data_out, data_valid_out, len_out, full_out, empty_out
    );

    modport slave (
        input  data_in, data_ready_in, dequeue_in,
        output ack_out, data_out, data_valid_out, len_out, full_out, empty_out
    );

endinterface

// File: rtl/byte_queue_mem.sv
// Register-array storage for byte_queue: one synchronous write port and one
// synchronous read port whose output register holds the last dequeued word.
module byte_queue_mem #(
    parameter int DEPTH = deserializer_pkg::QUEUE_DEPTH,
    parameter int WIDTH = deserializer_pkg::WORD_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // NOTE: the array has no reset; occupancy tracking guarantees no entry is read before it is written.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/byte_queue.sv
// Eight-entry circular FIFO behind the deserializer: captures each pending word
// with a one-cycle ack, withholds the ack while full, and pops on dequeue.
module byte_queue
    import deserializer_pkg::*;
#(
    parameter int DEPTH = QUEUE_DEPTH,
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic         clock,
    input  logic         reset,
    byte_queue_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    capture_state_t   state_q;
    logic             ack_q;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             valid_q,  valid_d;

    logic             capture;
    logic             pop;

    // Both decisions look only at registered count, so a pop never frees space for a same-cycle capture.
    assign capture = (state_q == WAIT_DATA) && bus.data_ready_in && (count_q < FULL_COUNT);
    assign pop     = bus.dequeue_in && (count_q != '0);

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = pop;

        if (capture) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({capture, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    // ack_q is high exactly while the FSM sits in ACK, and ACK always exits after one cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= WAIT_DATA;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                WAIT_DATA: begin
                    if (capture) begin
                        state_q <= ACK;
                        ack_q   <= 1'b1;
                    end
                end
                ACK: begin
                    state_q <= WAIT_DROP;
                end
                WAIT_DROP: begin
                    if (!bus.data_ready_in) begin
                        state_q <= WAIT_DATA;
                    end
                end
                default: begin
                    state_q <= WAIT_DATA;
                end
            endcase
        end
    end

    byte_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (capture),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.data_in),
        .rd_en   (pop),
        .rd_addr (rd_ptr_q),
        .rd_data (bus.data_out)
    );

    assign bus.ack_out        = ack_q;
    assign bus.data_valid_out = valid_q;
    assign bus.len_out        = count_q;
    assign bus.full_out       = (count_q == FULL_COUNT);
    assign bus.empty_out      = (count_q == '0);

endmodule
